// File: rtl/fp_add_result_stage.sv
// fp_add_result_stage: result buffer behind a combinational FP adder.
//
// Captures adder results with their exception flags in a DEPTH-entry FIFO and
// presents the oldest entry to the consumer through a valid/ready handshake.
// It also keeps sticky {NV, OF, UF} flags accumulated over all pushed results.
//
// Optional feature: define FP_STICKY_FLAGS_EN to build the sticky flag
// register. Without it, sticky_flags reads 0 and flags_clr is ignored.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - synchronous active-high reset
//   in_valid     - adder result present this cycle
//   in_ready     - stage can accept a result (registered state only)
//   in_result    - 32-bit fp result, stored unmodified
//   in_overflow  - adder overflow flag
//   in_underflow - adder underflow flag
//   out_valid    - head entry valid
//   out_ready    - consumer accepts head entry
//   out_result   - head entry result, 0 when empty
//   out_flags    - head entry flags {NV, OF, UF}, 0 when empty
//   sticky_flags - accumulated {NV, OF, UF} since last clear
//   flags_clr    - clear sticky flags
//   count        - number of occupied entries
module fp_add_result_stage #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic                       in_overflow,
  input  logic                       in_underflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [2:0]                 out_flags,
  output logic [2:0]                 sticky_flags,
  input  logic                       flags_clr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [31:0]   result_mem [DEPTH];
  logic [2:0]    flags_mem  [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic       push;
  logic       pop;
  logic       in_nv;
  logic [2:0] in_flags;

  // Handshake status comes from the occupancy register alone, so in_ready has
  // no path from out_ready: a full buffer refuses a push even while popping.
  assign in_ready  = (count_q < FullCount);
  assign out_valid = (count_q != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Invalid-operation: exponent all ones with a non-zero mantissa (NaN).
  assign in_nv    = (in_result[30:23] == 8'hFF) && (in_result[22:0] != 23'd0);
  assign in_flags = {in_nv, in_overflow, in_underflow};

  // Storage is not reset; empty-state outputs are forced to zero below.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      result_mem[wr_ptr_q] <= in_result;
      flags_mem[wr_ptr_q]  <= in_flags;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    out_result = '0;
    out_flags  = '0;
    if (out_valid) begin
      out_result = result_mem[rd_ptr_q];
      out_flags  = flags_mem[rd_ptr_q];
    end
  end

  assign count = count_q;

`ifdef FP_STICKY_FLAGS_EN
  logic [2:0] sticky_q;

  // A clear coinciding with a push leaves only that push's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (flags_clr) begin
      sticky_q <= push ? in_flags : 3'b000;
    end else if (push) begin
      sticky_q <= sticky_q | in_flags;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign sticky_flags     = 3'b000;
`endif

endmodule

// File: tb/tb_fp_add_result_stage.sv
// Self-checking bench for fp_add_result_stage (DEPTH = 4).
// A queue-based reference model is advanced at every rising edge and compared
// against all DUT outputs on the following falling edge; directed scenarios add
// hand-computed literal expectations on top.
module tb_fp_add_result_stage;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

`ifdef FP_STICKY_FLAGS_EN
  localparam logic [2:0] StickyMask = 3'b111;
`else
  localparam logic [2:0] StickyMask = 3'b000;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_result;
  logic          in_overflow;
  logic          in_underflow;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [2:0]    out_flags;
  logic [2:0]    sticky_flags;
  logic          flags_clr;
  logic [CW-1:0] count;

  fp_add_result_stage #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flags_clr    (flags_clr),
    .count        (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: each entry is {result, NV, OF, UF}.
  logic [34:0] mq[$];
  logic [2:0]  m_sticky = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [2:0] f;
    bit         push;
    bit         pop;
    if (rst) begin
      mq.delete();
      m_sticky = 3'b000;
      return;
    end
    f    = {(in_result[30:23] == 8'hFF) && (in_result[22:0] != 23'd0), in_overflow, in_underflow};
    push = in_valid && (mq.size() < DEPTH);
    pop  = out_ready && (mq.size() != 0);
    if (pop) mq.delete(0);
    if (push) mq.push_back({in_result, f});
    if (flags_clr) m_sticky = push ? f : 3'b000;
    else if (push) m_sticky = m_sticky | f;
    m_sticky = m_sticky & StickyMask;
  endtask

  task automatic model_compare();
    logic [31:0] e_res;
    logic [2:0]  e_flg;
    e_res = 32'd0;
    e_flg = 3'd0;
    if (mq.size() != 0) begin
      e_res = mq[0][34:3];
      e_flg = mq[0][2:0];
    end
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_out_result", out_result, e_res);
    chk("m_out_flags", {29'd0, out_flags}, {29'd0, e_flg});
    chk("m_sticky", {29'd0, sticky_flags}, {29'd0, m_sticky});
  endtask

  // One clock: model follows the edge, outputs compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_en) model_compare();
  endtask

  task automatic drv(input logic v, input logic [31:0] r, input logic ov, input logic uf,
                     input logic ordy, input logic clr);
    in_valid     = v;
    in_result    = r;
    in_overflow  = ov;
    in_underflow = uf;
    out_ready    = ordy;
    flags_clr    = clr;
    tick();
  endtask

  logic [31:0] pat [4] = '{32'h7fc00000, 32'h7f800000, 32'hff800001, 32'h3f800000};

  initial begin
    rst = 1'b1;
    drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);

    // Single push with latency 1, then empty; popping when empty is ignored.
    drv(1'b1, 32'h00140000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_result", out_result, 32'h00140000);
    chk("single_flags", {29'd0, out_flags}, 32'd0);
    drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("single_empty", {31'd0, out_valid}, 32'd0);
    drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_pop_count", 32'(count), 32'd0);

    // Fill: fifth push is dropped, pops return the first four in order.
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 32'h3f800000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 3) begin
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_count", 32'(count), 32'd4);
      end
    end
    chk("fill_count_after5", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", out_result, 32'h3f800000 + 32'(i));
      drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("fill_drained", 32'(count), 32'd0);

    // NaN then infinity with overflow.
    drv(1'b1, 32'h7fc00000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nan_flags", {29'd0, out_flags}, 32'b100);
    drv(1'b1, 32'h7f800000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("nan_of_sticky", {29'd0, sticky_flags}, {29'd0, 3'b110 & StickyMask});
    drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("of_flags", {29'd0, out_flags}, 32'b010);
    chk("of_result", out_result, 32'h7f800000);
    drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear coinciding with an underflow push.
    drv(1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_push_sticky", {29'd0, sticky_flags}, {29'd0, 3'b001 & StickyMask});
    chk("clr_push_flags", {29'd0, out_flags}, 32'b001);
    drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Full with simultaneous pop: no push.
    for (int i = 0; i < 4; i++) drv(1'b1, 32'h40000000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    drv(1'b1, 32'hdeadbeef, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_ready", {31'd0, in_ready}, 32'd1);
    chk("full_pop_head", out_result, 32'h40000001);

    // Reset mid-traffic with push and pop requested.
    drv(1'b1, 32'h7fc00001, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drv(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sticky", {29'd0, sticky_flags}, 32'd0);
    chk("midrst_result", out_result, 32'd0);

    // Mixed traffic against the model.
    for (int i = 0; i < 80; i++) begin
      drv(1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) != 0) ? pat[$urandom_range(0, 3)] : $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
